clb_multi: RTL and testbench
============================

# clb_multi

Parametrised multi-BLE configurable logic block and successor to the single-BLE CLB. It holds `BLE_NUM` K-input LUT/flip-flop elements behind a full input crossbar, with registered feedback from every BLE. Configuration is loaded through a serial scan chain on the same clock as user logic. An on-block load controller counts shifted bits and only enables logic outputs after an exact-length load, which adds load validation and readback. It sits in the FPGA fabric tile between the connection blocks (`clb_in`) and the switch-box output pins (`out`).

## Interface
- `LUT_K`, 4, LUT inputs per BLE
- `BLE_NUM`, 4, BLEs per CLB; one output each
- `CLB_IN_WIDTH`, 10, external CLB inputs
- `SEL_WIDTH`, clog2(CLB_IN_WIDTH+BLE_NUM+1), crossbar select bits per LUT input
- Derived: `BLE_BITS` = 1 + LUT_K*SEL_WIDTH + 2^LUT_K; `CFG_BITS` = BLE_NUM*BLE_BITS
- Ports:
- `clk` in 1: single clock for scan and user logic (rising edge)
- `rst` in 1: asynchronous, active-high reset
- `scan_en` in 1: 1 = shift configuration
- `scan_in` in 1: serial configuration data
- `scan_out` out 1: serial chain output (= cfg[0])
- `clb_in` in CLB_IN_WIDTH: user logic inputs
- `ff_en` in 1: BLE flip-flop clock enable
- `out` out BLE_NUM: BLE outputs
- `cfg_done` out 1: configuration valid, logic active
- `cfg_err` out 1: last load had the wrong bit count (sticky)

## Operation
- Config register cfg[CFG_BITS-1:0]. When scan_en=1, each clk does cfg <= {scan_in, cfg[CFG_BITS-1:1]}. The first bit shifted in ends at cfg[0] after CFG_BITS shifts. scan_out = cfg[0], so readback is FIFO order.
- BLE b field base = b*BLE_BITS:
  - is_comb at base.
  - Select for LUT input i at base+1+i*SEL_WIDTH, LSB first.
  - LUT entry a at base+1+LUT_K*SEL_WIDTH+a.
- Crossbar source vector is {1'b0, ff_q[BLE_NUM-1:0], clb_in}. Index 0..CLB_IN_WIDTH-1 selects clb_in, the next BLE_NUM indices select the BLE flops, and index CLB_IN_WIDTH+BLE_NUM selects constant 0. Any larger select value yields 0.
- LUT output = lut[addr], addr = {in[K-1],…,in[0]}.
- ff_q[b] <= lut_out[b] when state=ACTIVE, scan_en=0 and ff_en=1; otherwise it holds.
- out[b] = is_comb ? lut_out[b] : ff_q[b]. out is forced to 0 when state≠ACTIVE or scan_en=1; the scan_en term is combinational gating.
- Feedback uses flop outputs only, so there are no combinational loops.
- Controller state machine:
  - UNCONFIG → SHIFT on a clk with scan_en=1.
  - ACTIVE → SHIFT on a clk with scan_en=1.
  - SHIFT stays in SHIFT while scan_en=1 and increments the bit counter, which saturates at CFG_BITS+1.
  - SHIFT → ACTIVE on the first clk with scan_en=0 if count==CFG_BITS; cfg_err <= 0.
  - SHIFT → UNCONFIG on the first clk with scan_en=0 if count≠CFG_BITS; cfg_err <= 1.
  - Entering SHIFT clears the counter to 1, clears all ff_q to 0, and clears cfg_err.
- cfg_done = (state==ACTIVE), registered.
- Reset: cfg=0, ff_q=0, counter=0, state=UNCONFIG. All outputs 0: out=0, scan_out=0, cfg_done=0, cfg_err=0.
- Reset mid-shift aborts the load completely; a new full load is required.

## Timing
- Shift: one bit per clk while scan_en=1. The first bit appears at scan_out after CFG_BITS clocks.
- Load completion: cfg_done rises on the clk edge that samples scan_en=0, i.e. 1 cycle after the last shift edge.
- Combinational path (is_comb=1, ACTIVE): clb_in → out in the same cycle, 0 latency.
- Registered path: out updates 1 clk after the inputs are sampled.
- Feedback: the flop value seen by the crossbar is the previous-cycle lut_out.
- out drops to 0 in the same cycle scan_en rises; cfg_done drops on the next edge.
- ff_en=0: flops hold indefinitely; combinational outputs are unaffected.

## Test plan
Use LUT_K=4, BLE_NUM=2, CLB_IN_WIDTH=6. This gives SEL_WIDTH=4, BLE_BITS=33, CFG_BITS=66. Crossbar index 6 = ff_q[0], 7 = ff_q[1], 8 = constant 0.
- Reset check: assert rst with random scan_en and clb_in → out=0, scan_out=0, cfg_done=0, cfg_err=0, held through reset.
- Combinational AND4: load 66 bits with BLE0 is_comb=1, sel=0,1,2,3, LUT=0x8000; BLE1 all zero. Expect cfg_done=1 one cycle after scan_en falls. Then clb_in=6'b001111 → out[0]=1 in the same cycle; clb_in=6'b001110 → out[0]=0.
- Toggle flop: BLE1 is_comb=0, sel0=7, sel1..3=8, LUT=0x5555; ff_en=1 → out[1] = 0,1,0,1 on successive edges. ff_en=0 for 3 cycles → out[1] holds its value.
- Bad length: shift 65 bits, then separately 67 bits → cfg_err=1, cfg_done=0, out=0 in both cases. A following correct 66-bit load → cfg_err=0, cfg_done=1.
- Readback: after the toggle-flop load, shift 66 zeros → scan_out reproduces the loaded stream in load order. Afterwards cfg_done=1 and out=2'b00 for all clb_in.
- Reset mid-shift: pulse rst after 30 shifted bits → cfg=0, cfg_done=0, cfg_err=0. Then scan_en=0 → state stays UNCONFIG and out=0.

Source files
------------

// File: rtl/clb_multi.sv
// Multi-BLE configurable logic block: serial-scan configured K-LUT/flop elements
// behind a full input crossbar, with a load controller that validates load length.
module clb_multi #(
    parameter int LUT_K        = 4,
    parameter int BLE_NUM      = 4,
    parameter int CLB_IN_WIDTH = 10,
    parameter int SEL_WIDTH    = $clog2(CLB_IN_WIDTH + BLE_NUM + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_en,
    input  logic                    scan_in,
    output logic                    scan_out,
    input  logic [CLB_IN_WIDTH-1:0] clb_in,
    input  logic                    ff_en,
    output logic [BLE_NUM-1:0]      out,
    output logic                    cfg_done,
    output logic                    cfg_err
);

    localparam int LUT_SIZE = 1 << LUT_K;
    localparam int BLE_BITS = 1 + LUT_K * SEL_WIDTH + LUT_SIZE;
    localparam int CFG_BITS = BLE_NUM * BLE_BITS;
    localparam int SRC_PAD  = 1 << SEL_WIDTH;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    typedef enum logic [1:0] {
        UNCONFIG = 2'd0,
        SHIFT    = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CFG_BITS-1:0]  cfg;
    logic [BLE_NUM-1:0]   ff_q;
    logic [BLE_NUM-1:0]   lut_out;
    logic [BLE_NUM-1:0]   is_comb;
    logic [SRC_PAD-1:0]   src_pad;
    logic                 enter_shift;
    logic                 load_ok;
    logic                 load_bad;
    logic                 run_logic;

    // Padding the source vector to every encodable select value makes all
    // out-of-range selects, including the explicit constant slot, read 0.
    assign src_pad   = SRC_PAD'({ff_q, clb_in});
    assign run_logic = (state_q == ACTIVE) && !scan_en;
    assign scan_out  = cfg[0];

    for (genvar b = 0; b < BLE_NUM; b++) begin : g_ble
        localparam int BASE = b * BLE_BITS;
        logic [LUT_K-1:0]    addr;
        logic [LUT_SIZE-1:0] lut_bits;

        assign lut_bits   = cfg[BASE + 1 + LUT_K * SEL_WIDTH +: LUT_SIZE];
        assign is_comb[b] = cfg[BASE];
        assign lut_out[b] = lut_bits[addr];

        always_comb begin
            addr = '0;
            for (int i = 0; i < LUT_K; i++) begin
                addr[i] = src_pad[cfg[BASE + 1 + i * SEL_WIDTH +: SEL_WIDTH]];
            end
        end
    end

    assign out = run_logic ? ((is_comb & lut_out) | (~is_comb & ff_q)) : '0;

    always_comb begin
        state_d     = state_q;
        enter_shift = 1'b0;
        load_ok     = 1'b0;
        load_bad    = 1'b0;
        case (state_q)
            UNCONFIG, ACTIVE: begin
                if (scan_en) begin
                    state_d     = SHIFT;
                    enter_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (!scan_en) begin
                    if (cnt_q == CNT_FULL) begin
                        state_d = ACTIVE;
                        load_ok = 1'b1;
                    end else begin
                        state_d  = UNCONFIG;
                        load_bad = 1'b1;
                    end
                end
            end
            default: state_d = UNCONFIG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNCONFIG;
            cnt_q    <= '0;
            cfg_err  <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_done <= (state_d == ACTIVE);
            if (enter_shift) begin
                cnt_q   <= CNT_W'(1);
                cfg_err <= 1'b0;
            end else if (state_q == SHIFT && scan_en && cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (load_ok) begin
                cfg_err <= 1'b0;
            end else if (load_bad) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Configuration chain and BLE flops; a new load always starts from cleared flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg  <= '0;
            ff_q <= '0;
        end else begin
            if (scan_en) begin
                cfg <= {scan_in, cfg[CFG_BITS-1:1]};
            end
            if (enter_shift) begin
                ff_q <= '0;
            end else if (run_logic && ff_en) begin
                ff_q <= lut_out;
            end
        end
    end

endmodule

// File: tb/tb_clb_multi.sv
// Directed bench for clb_multi (K=4, 2 BLEs, 6 inputs) with a behavioural
// reference model checked every cycle plus hand-computed expectations.
module tb_clb_multi;

    localparam int K   = 4;
    localparam int N   = 2;
    localparam int W   = 6;
    localparam int BB  = 33;
    localparam int CFG = 66;

    logic         clk = 1'b0;
    logic         rst;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic [W-1:0] clb_in;
    logic         ff_en;
    logic [N-1:0] out;
    logic         cfg_done;
    logic         cfg_err;

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;

    clb_multi #(.LUT_K(K), .BLE_NUM(N), .CLB_IN_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out), .clb_in(clb_in), .ff_en(ff_en), .out(out),
        .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: the loaded bit stream, whether a load is in progress,
    // how many bits it has seen, and whether logic is live.
    logic [CFG-1:0] m_cfg;
    logic [N-1:0]   m_ff;
    logic           m_in_load, m_active, m_err;
    int             m_count;

    function automatic logic m_lut(int b, logic [W-1:0] cin);
        int base = b * BB;
        int addr = 0;
        for (int i = 0; i < K; i++) begin
            int sel = 0;
            int v;
            for (int j = 0; j < 4; j++) sel += int'(m_cfg[base + 1 + i * 4 + j]) << j;
            if (sel < W)          v = int'(cin[sel]);
            else if (sel < W + N) v = int'(m_ff[sel - W]);
            else                  v = 0;
            addr += v << i;
        end
        return m_cfg[base + 1 + K * 4 + addr];
    endfunction

    function automatic logic [N-1:0] m_out();
        logic [N-1:0] o = '0;
        if (m_active && !m_in_load && !scan_en)
            for (int b = 0; b < N; b++)
                o[b] = m_cfg[b * BB] ? m_lut(b, clb_in) : m_ff[b];
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cfg <= '0; m_ff <= '0; m_in_load <= 1'b0;
            m_active <= 1'b0; m_err <= 1'b0; m_count <= 0;
        end else if (scan_en) begin
            m_cfg <= {scan_in, m_cfg[CFG-1:1]};
            if (!m_in_load) begin
                m_in_load <= 1'b1; m_count <= 1; m_ff <= '0; m_err <= 1'b0;
            end else begin
                m_count <= m_count + 1;
            end
        end else if (m_in_load) begin
            m_in_load <= 1'b0;
            m_active  <= (m_count == CFG);
            m_err     <= (m_count != CFG);
        end else if (m_active && ff_en) begin
            m_ff <= {m_lut(1, clb_in), m_lut(0, clb_in)};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_out",      32'(out),      32'(m_out()));
            chk("model_scan_out", 32'(scan_out), 32'(m_cfg[0]));
            chk("model_cfg_done", 32'(cfg_done), 32'(m_active && !m_in_load));
            chk("model_cfg_err",  32'(cfg_err),  32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [CFG-1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            scan_en = 1'b1;
            scan_in = (i < CFG) ? c[i] : 1'b0;
        end
        tick();
        scan_en = 1'b0;
        scan_in = 1'b0;
        tick();
    endtask

    function automatic logic [BB-1:0] mk_ble(logic comb, logic [3:0] s0, logic [3:0] s1,
                                             logic [3:0] s2, logic [3:0] s3, logic [15:0] lut);
        return {lut, s3, s2, s1, s0, comb};
    endfunction

    logic [CFG-1:0] and_cfg, tog_cfg;
    logic [W-1:0]   pats [4];

    initial begin
        and_cfg = {{BB{1'b0}}, mk_ble(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 16'h8000)};
        tog_cfg = {mk_ble(1'b0, 4'd7, 4'd8, 4'd8, 4'd8, 16'h5555),
                   mk_ble(1'b1, 4'd0, 4'd1, 4'd2, 4'd3, 16'h8000)};
        pats[0] = 6'b001111; pats[1] = 6'b111111; pats[2] = 6'b000000; pats[3] = 6'b101010;

        rst = 1'b1; scan_en = 1'b0; scan_in = 1'b0; clb_in = '0; ff_en = 1'b0;
        chk_on = 1'b1;
        // Reset held with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            tick();
            scan_en = 1'($urandom); scan_in = 1'($urandom); clb_in = W'($urandom);
            @(negedge clk);
            chk("rst_out", 32'(out), 0);
            chk("rst_scan_out", 32'(scan_out), 0);
            chk("rst_cfg_done", 32'(cfg_done), 0);
            chk("rst_cfg_err", 32'(cfg_err), 0);
        end
        tick();
        rst = 1'b0; scan_en = 1'b0; scan_in = 1'b0; clb_in = '0;

        // Combinational AND4 on BLE0.
        load(and_cfg, CFG);
        clb_in = 6'b001111;
        @(negedge clk);
        chk("and_cfg_done", 32'(cfg_done), 1);
        chk("and_hit", 32'(out[0]), 1);
        tick();
        clb_in = 6'b001110;
        @(negedge clk);
        chk("and_miss", 32'(out[0]), 0);

        // Wrong-length loads.
        clb_in = 6'b001111;
        load(and_cfg, CFG - 1);
        @(negedge clk);
        chk("short_err", 32'(cfg_err), 1);
        chk("short_done", 32'(cfg_done), 0);
        chk("short_out", 32'(out), 0);
        load(and_cfg, CFG + 1);
        @(negedge clk);
        chk("long_err", 32'(cfg_err), 1);
        chk("long_done", 32'(cfg_done), 0);
        chk("long_out", 32'(out), 0);

        // Correct load with a toggle flop on BLE1.
        ff_en = 1'b1;
        load(tog_cfg, CFG);
        @(negedge clk);
        chk("good_err", 32'(cfg_err), 0);
        chk("good_done", 32'(cfg_done), 1);
        chk("tog_0", 32'(out[1]), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            @(negedge clk);
            chk("tog_seq", 32'(out[1]), 32'(i % 2));
        end
        ff_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("tog_hold", 32'(out[1]), 1);
        end

        // Readback of the toggle configuration while shifting zeros.
        for (int i = 0; i < CFG; i++) begin
            tick();
            scan_en = 1'b1; scan_in = 1'b0;
            @(negedge clk);
            chk("readback", 32'(scan_out), 32'(tog_cfg[i]));
        end
        tick();
        scan_en = 1'b0;
        tick();
        @(negedge clk);
        chk("zero_cfg_done", 32'(cfg_done), 1);
        for (int p = 0; p < 4; p++) begin
            tick();
            clb_in = pats[p];
            @(negedge clk);
            chk("zero_out", 32'(out), 0);
        end

        // Reset in the middle of a load.
        for (int i = 0; i < 30; i++) begin
            tick();
            scan_en = 1'b1; scan_in = 1'($urandom);
        end
        tick();
        rst = 1'b1; scan_en = 1'b0;
        tick();
        rst = 1'b0;
        clb_in = 6'b001111;
        @(negedge clk);
        chk("mid_rst_done", 32'(cfg_done), 0);
        chk("mid_rst_err", 32'(cfg_err), 0);
        chk("mid_rst_scan_out", 32'(scan_out), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("mid_rst_out", 32'(out), 0);
            chk("mid_rst_idle_done", 32'(cfg_done), 0);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
